// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Define MULTDIV_EARLY_OUT_EN to end a multiply once the remaining multiplier bits are zero.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_cancel,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [2*WIDTH-1:0] NEG_LIM =
        {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] POS_LIM =
        {{WIDTH{1'b0}}, 1'b0, {(WIDTH-1){1'b1}}};

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               op_div, sgn, dz_pend;
    logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
    logic [WIDTH-1:0]   mplier, dvsr, quo, rem;
    logic [TAG_W-1:0]   tag_r;
    logic [WIDTH-1:0]   res_q;
    logic               exc_q;
    logic [TAG_W-1:0]   tag_q;

    logic               start, accept, dz_start, early, finish, take;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_nxt, quo_nxt;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   mul_res, div_res, fin_res;
    logic               mul_exc, div_exc, fin_exc;

    assign start    = ctrl_MULT ^ ctrl_DIV;
    assign accept   = start & (state != RUN) & ~dz_pend & ~ctrl_cancel;
    assign dz_start = ctrl_DIV & (data_operandB == '0);

`ifdef MULTDIV_EARLY_OUT_EN
    assign early = ~op_div & (cnt != '0) & (mplier == '0);
`else
    assign early = 1'b0;
`endif

    assign finish = (state == RUN) & ((cnt == LAST) | early);

    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        acc_nxt = mplier[0] ? acc + mcand : acc;
        shifted = {rem, quo[WIDTH-1]};
        take    = shifted >= {1'b0, dvsr};
        rem_nxt = take ? shifted[WIDTH-1:0] - dvsr : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], take};
        mul_res = sgn ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        mul_exc = sgn ? (acc > NEG_LIM) : (acc > POS_LIM);
        // only MIN / -1 yields a positive quotient with the top bit set
        div_res = sgn ? -quo : quo;
        div_exc = ~sgn & quo[WIDTH-1];
        fin_res = op_div ? div_res : mul_res;
        fin_exc = op_div ? div_exc : mul_exc;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_cancel) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = dz_start ? IDLE : RUN;
        end else begin
            unique case (state)
                IDLE:    if (dz_pend) state_nxt = DONE;
                RUN:     if (finish) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            op_div  <= 1'b0;
            sgn     <= 1'b0;
            dz_pend <= 1'b0;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            dvsr    <= '0;
            quo     <= '0;
            rem     <= '0;
            tag_r   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            tag_q   <= '0;
        end else if (ctrl_cancel) begin
            dz_pend <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            op_div  <= ctrl_DIV;
            sgn     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_pend <= dz_start;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            acc     <= '0;
            mplier  <= b_mag;
            dvsr    <= b_mag;
            quo     <= a_mag;
            rem     <= '0;
            tag_r   <= in_tag;
        end else if (dz_pend) begin
            // divide by zero skips iteration entirely
            dz_pend <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b1;
            tag_q   <= tag_r;
        end else if (state == RUN) begin
            if (finish) begin
                res_q <= fin_res;
                exc_q <= fin_exc;
                tag_q <= tag_r;
            end else begin
                cnt <= cnt + CW'(1);
                if (op_div) begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                end else begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
            end
        end
    end

    assign busy           = (state == RUN);
    assign data_resultRDY = (state == DONE);
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign out_tag        = tag_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: arithmetic reference model with per-cycle compare plus literal vectors.
// Early-out latency expectations follow MULTDIV_EARLY_OUT_EN.
module tb_multdiv_seq;

    localparam int W = 32;
    localparam int T = 5;
    localparam longint MAXV = 2147483647;
    localparam longint MINV = -MAXV - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_MULT = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic         ctrl_cancel = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [T-1:0] in_tag = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;
    logic [T-1:0] out_tag;

    multdiv_seq #(.WIDTH(W), .TAG_W(T)) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .ctrl_cancel(ctrl_cancel),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .in_tag(in_tag),
        .data_result(data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy),
        .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] ref_op(input bit mul,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, r;
        bit ex;
        sa = $signed(a);
        sb = $signed(b);
        if (!mul && sb == 0) return {1'b1, 32'h0};
        r  = mul ? sa * sb : sa / sb;
        ex = (r > MAXV) || (r < MINV);
        return {ex, r[31:0]};
    endfunction

    function automatic int ref_lat(input bit mul, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!mul && b == 0) return 1;
`ifdef MULTDIV_EARLY_OUT_EN
        if (mul) begin
            logic [31:0] mb;
            int n;
            mb = b[31] ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
            return n + 1;
        end
`endif
        return (a == a) ? W + 1 : W + 1;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // reference: one pending op completes at a fixed edge unless dropped
    bit           pend = 1'b0;
    bit           pend_dz = 1'b0;
    int           due = 0;
    logic [32:0]  p_op = '0;
    logic [T-1:0] p_tag = '0;
    logic         m_rdy = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_exc = 1'b0;
    logic [T-1:0] m_tag = '0;
    logic         m_busy;

    assign m_busy = pend & ~pend_dz;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_dz <= 1'b0;
            m_rdy   <= 1'b0;
            m_res   <= '0;
            m_exc   <= 1'b0;
            m_tag   <= '0;
        end else begin
            m_rdy <= 1'b0;
            if (ctrl_cancel) begin
                pend <= 1'b0;
            end else begin
                if (pend && cyc + 1 == due) begin
                    m_rdy <= 1'b1;
                    m_res <= p_op[31:0];
                    m_exc <= p_op[32];
                    m_tag <= p_tag;
                    pend  <= 1'b0;
                end
                if (!pend && (ctrl_MULT ^ ctrl_DIV)) begin
                    pend    <= 1'b1;
                    pend_dz <= ctrl_DIV && data_operandB == 0;
                    due     <= cyc + 1 +
                        ref_lat(ctrl_MULT, data_operandA, data_operandB);
                    p_op    <= ref_op(ctrl_MULT, data_operandA, data_operandB);
                    p_tag   <= in_tag;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (chk_en) begin
                check("rdy", data_resultRDY, m_rdy);
                check("busy", busy, m_busy);
                check("result", data_result, m_res);
                check("exc", data_exception, m_exc);
                check("tag", out_tag, m_tag);
            end
        end
    end

    task automatic start_op(input bit mul, input logic [31:0] a,
                            input logic [31:0] b, input logic [T-1:0] t,
                            output int n);
        ctrl_MULT = mul;
        ctrl_DIV = !mul;
        data_operandA = a;
        data_operandB = b;
        in_tag = t;
        @(posedge clock);
        #1 n = cyc;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, output int e);
        e = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                e = cyc;
                break;
            end
        end
    endtask

    task automatic run_chk(input string nm, input bit mul,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [T-1:0] t, input int lat,
                           input logic [31:0] res, input bit exc);
        int n, e;
        start_op(mul, a, b, t, n);
        wait_rdy(60, e);
        check({nm, "_lat"}, e - n, lat);
        check({nm, "_res"}, data_result, res);
        check({nm, "_exc"}, data_exception, exc);
        check({nm, "_tag"}, out_tag, t);
    endtask

    initial begin
        int n, n2, e, seen;
        int early_lat;
`ifdef MULTDIV_EARLY_OUT_EN
        early_lat = 2;
`else
        early_lat = 33;
`endif
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        check("rst_res", data_result, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clock);

        run_chk("m7x-3", 1, 7, -3, 5, 33, 32'hFFFFFFEB, 0);
        @(negedge clock);
        run_chk("movf", 1, 32'h40000000, 4, 3, 33, 0, 1);
        @(negedge clock);
        run_chk("d-7/2", 0, -7, 2, 7, 33, 32'hFFFFFFFD, 0);
        @(negedge clock);
        run_chk("dmin", 0, 32'h80000000, -1, 1, 33, 32'h80000000, 1);
        @(negedge clock);
        run_chk("dz", 0, 5, 0, 2, 1, 0, 1);
        @(negedge clock);
        run_chk("mmin", 1, 32'h80000000, 1, 4, 33, 32'h80000000, 0);
        @(negedge clock);
        run_chk("d100", 0, 100, -7, 9, 33, 32'hFFFFFFF2, 0);
        run_chk("b2b", 1, -5, -6, 10, 33, 30, 0);
        @(negedge clock);
        run_chk("early", 1, 5, 1, 11, early_lat, 5, 0);
        @(negedge clock);

        start_op(1, 3, 4, 12, n);
        repeat (4) @(negedge clock);
        start_op(1, 100, 100, 13, n2);
        wait_rdy(60, e);
        check("ign_lat", e - n, 33);
        check("ign_res", data_result, 12);
        check("ign_tag", out_tag, 12);
        @(negedge clock);

        ctrl_MULT = 1'b1;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        check("both_busy", busy, 0);
        ctrl_MULT = 1'b1;
        ctrl_cancel = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_cancel = 1'b0;
        check("cxs_busy", busy, 0);

        start_op(1, 9, 9, 14, n);
        repeat (9) @(negedge clock);
        ctrl_cancel = 1'b1;
        @(negedge clock);
        ctrl_cancel = 1'b0;
        check("cx_busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check("cx_norpy", seen, 0);

        start_op(0, 1000, 3, 15, n);
        repeat (11) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rs_res", data_result, 0);
        check("rs_exc", data_exception, 0);
        check("rs_rdy", data_resultRDY, 0);
        check("rs_busy", busy, 0);
        check("rs_tag", out_tag, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        check("rs_norpy", seen, 0);

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
